// File: rtl/pepelatz_mem_responder_if.sv
// Core-side bus of the Pepelatz memory responder: ROM fetch port plus RAM data port.
// There is no request strobe; a request is whatever address/mode/data the core presents.
interface pepelatz_mem_responder_if;
  logic [15:0] rom_address;
  logic [15:0] rom_data;
  logic        rom_ready;
  logic        ram_write;
  logic [15:0] ram_adress;
  logic [15:0] ram_input;
  logic [15:0] ram_data;
  logic        ram_ready;

  modport master (
    output rom_address, ram_write, ram_adress, ram_input,
    input  rom_data, rom_ready, ram_data, ram_ready
  );

  modport slave (
    input  rom_address, ram_write, ram_adress, ram_input,
    output rom_data, rom_ready, ram_data, ram_ready
  );
endinterface

// File: rtl/pepelatz_mem_responder.sv
// Unified single-port word memory serving the Pepelatz ROM fetch and RAM data ports through one
// wait-stated access engine; requests are inferred from per-port tags of the last served access.
module pepelatz_mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input logic                    clk,
  input logic                    rst,
  pepelatz_mem_responder_if.slave bus
);

  localparam int          DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   ptr_rom_q, ptr_rom_d;
  logic                   gnt_rom_q, gnt_rom_d;
  logic [ADDR_BITS-1:0]   eng_addr_q, eng_addr_d;
  logic                   eng_write_q, eng_write_d;
  logic [15:0]            eng_wdata_q, eng_wdata_d;

  logic [ADDR_BITS-1:0]   rom_tag_q, rom_tag_d;
  logic                   rom_valid_q, rom_valid_d;
  logic [ADDR_BITS-1:0]   ram_tag_addr_q, ram_tag_addr_d;
  logic                   ram_tag_write_q, ram_tag_write_d;
  logic [15:0]            ram_tag_data_q, ram_tag_data_d;
  logic                   ram_valid_q, ram_valid_d;

  logic [15:0]            rom_data_q, rom_data_d;
  logic [15:0]            ram_data_q, ram_data_d;

  logic [15:0]            mem_q [DEPTH];
  logic [15:0]            mem_rdata;

  logic [ADDR_BITS-1:0]   rom_addr_l, ram_addr_l;
  logic                   rom_hit, ram_hit;
  logic                   take_rom;
  logic                   commit;

  assign rom_addr_l = bus.rom_address[ADDR_BITS-1:0];
  assign ram_addr_l = bus.ram_adress[ADDR_BITS-1:0];

  // Upper address bits alias by design.
  if (ADDR_BITS < 16) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^{bus.rom_address[15:ADDR_BITS], bus.ram_adress[15:ADDR_BITS]};
  end

  assign rom_hit = rom_valid_q && (rom_addr_l == rom_tag_q);
  assign ram_hit = ram_valid_q && (ram_addr_l == ram_tag_addr_q) &&
                   (bus.ram_write == ram_tag_write_q) &&
                   (!bus.ram_write || (bus.ram_input == ram_tag_data_q));

  assign bus.rom_ready = rom_hit;
  assign bus.ram_ready = ram_hit;
  assign bus.rom_data  = rom_data_q;
  assign bus.ram_data  = ram_data_q;

  assign mem_rdata = mem_q[eng_addr_q];

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ptr_rom_d       = ptr_rom_q;
    gnt_rom_d       = gnt_rom_q;
    eng_addr_d      = eng_addr_q;
    eng_write_d     = eng_write_q;
    eng_wdata_d     = eng_wdata_q;
    rom_tag_d       = rom_tag_q;
    rom_valid_d     = rom_valid_q;
    ram_tag_addr_d  = ram_tag_addr_q;
    ram_tag_write_d = ram_tag_write_q;
    ram_tag_data_d  = ram_tag_data_q;
    ram_valid_d     = ram_valid_q;
    rom_data_d      = rom_data_q;
    ram_data_d      = ram_data_q;
    take_rom        = 1'b0;
    commit          = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rom_hit || !ram_hit) begin
          // A tie goes to the pointed port; the pointer then names the loser for next time.
          take_rom = !rom_hit && (ram_hit || ptr_rom_q);
          if (!rom_hit && !ram_hit) begin
            ptr_rom_d = !take_rom;
          end
          gnt_rom_d   = take_rom;
          eng_addr_d  = take_rom ? rom_addr_l : ram_addr_l;
          eng_write_d = !take_rom && bus.ram_write;
          eng_wdata_d = bus.ram_input;
          cnt_d       = WAIT_CNT;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
          if (gnt_rom_q) begin
            rom_data_d  = mem_rdata;
            rom_tag_d   = eng_addr_q;
            rom_valid_d = 1'b1;
          end else begin
            if (!eng_write_q) begin
              ram_data_d = mem_rdata;
            end else if (rom_tag_q == eng_addr_q) begin
              // A write under a fetched word invalidates the fetch so it is re-read.
              rom_valid_d = 1'b0;
            end
            ram_tag_addr_d  = eng_addr_q;
            ram_tag_write_d = eng_write_q;
            ram_tag_data_d  = eng_wdata_q;
            ram_valid_d     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ptr_rom_q   <= 1'b0;
      rom_valid_q <= 1'b0;
      ram_valid_q <= 1'b0;
      rom_data_q  <= 16'h0000;
      ram_data_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_rom_q   <= ptr_rom_d;
      rom_valid_q <= rom_valid_d;
      ram_valid_q <= ram_valid_d;
      rom_data_q  <= rom_data_d;
      ram_data_q  <= ram_data_d;
    end
  end

  // Engine latches and tag payloads are qualified by state/valid, so they need no reset.
  always_ff @(posedge clk) begin
    gnt_rom_q       <= gnt_rom_d;
    eng_addr_q      <= eng_addr_d;
    eng_write_q     <= eng_write_d;
    eng_wdata_q     <= eng_wdata_d;
    rom_tag_q       <= rom_tag_d;
    ram_tag_addr_q  <= ram_tag_addr_d;
    ram_tag_write_q <= ram_tag_write_d;
    ram_tag_data_q  <= ram_tag_data_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && eng_write_q) begin
      mem_q[eng_addr_q] <= eng_wdata_q;
    end
  end

endmodule

// File: tb/tb_pepelatz_mem_responder.sv
// Directed bench for pepelatz_mem_responder with WAIT_STATES=1 (access = 3 edges incl. grant).
module tb_pepelatz_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  pepelatz_mem_responder_if bus();

  pepelatz_mem_responder #(.ADDR_BITS(10), .WAIT_STATES(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ram_ready(input string name);
    for (int i = 0; i < 20 && !bus.ram_ready; i++) tick();
    checks++;
    if (bus.ram_ready !== 1'b1) $display("FAIL %s: ram_ready=%b, required 1 within 20 cycles", name, bus.ram_ready);
    else passed++;
  endtask

  task automatic wait_rom_ready(input string name);
    for (int i = 0; i < 20 && !bus.rom_ready; i++) tick();
    checks++;
    if (bus.rom_ready !== 1'b1) $display("FAIL %s: rom_ready=%b, required 1 within 20 cycles", name, bus.rom_ready);
    else passed++;
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
    bus.ram_write  = 1'b1;
    bus.ram_adress = addr;
    bus.ram_input  = data;
    #1;
    wait_ram_ready("write_done");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rom_address = 16'h0000;
    bus.ram_write   = 1'b0;
    bus.ram_adress  = 16'h0000;
    bus.ram_input   = 16'h0000;
    tick();
    tick();
    checks++; if (bus.rom_ready !== 1'b0) $display("FAIL reset_rom_ready: got %b want 0", bus.rom_ready); else passed++;
    checks++; if (bus.ram_ready !== 1'b0) $display("FAIL reset_ram_ready: got %b want 0", bus.ram_ready); else passed++;
    checks++; if (bus.rom_data !== 16'h0000) $display("FAIL reset_rom_data: got %h want 0000", bus.rom_data); else passed++;
    checks++; if (bus.ram_data !== 16'h0000) $display("FAIL reset_ram_data: got %h want 0000", bus.ram_data); else passed++;
  endtask

  task automatic preload();
    rst = 1'b0;
    do_write(16'h0000, 16'h1234);
    do_write(16'h0005, 16'h0505);
    do_write(16'h0006, 16'h0606);
    do_write(16'h0010, 16'h0007);
    do_write(16'h0100, 16'h1111);
    do_write(16'h0101, 16'h2222);
    do_write(16'h0102, 16'h3333);
    do_write(16'h0103, 16'h4444);
  endtask

  // After reset both ports are pending and the pointer favours RAM: RAM read done after
  // edge 3, ROM granted at edge 4 and done after edge 6.
  task automatic test_first_fetch();
    logic [1:0] exp;
    bus.ram_write   = 1'b0;
    bus.ram_adress  = 16'h0000;
    bus.ram_input   = 16'h0000;
    bus.rom_address = 16'h0000;
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.rom_ready, bus.ram_ready} !== 2'b00) $display("FAIL ff_reset_ready: got %b want 00", {bus.rom_ready, bus.ram_ready});
    else passed++;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = {k >= 6, k >= 3};
      checks++;
      if ({bus.rom_ready, bus.ram_ready} !== exp)
        $display("FAIL ff_ready_cycle%0d: {rom,ram}_ready=%b want %b", k, {bus.rom_ready, bus.ram_ready}, exp);
      else passed++;
    end
    checks++; if (bus.rom_data !== 16'h1234) $display("FAIL ff_rom_data: got %h want 1234", bus.rom_data); else passed++;
    checks++; if (bus.ram_data !== 16'h1234) $display("FAIL ff_ram_data: got %h want 1234", bus.ram_data); else passed++;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.rom_ready !== 1'b1) $display("FAIL ff_rom_hold%0d: rom_ready=%b want 1", k, bus.rom_ready); else passed++;
    end
  endtask

  task automatic test_write_read();
    do_write(16'h0040, 16'hBEEF);
    checks++; if (bus.ram_data !== 16'h1234) $display("FAIL wr_ram_data_kept: got %h want 1234", bus.ram_data); else passed++;
    bus.ram_write = 1'b0;
    #1;
    checks++; if (bus.ram_ready !== 1'b0) $display("FAIL wr_read_pending: ram_ready=%b want 0", bus.ram_ready); else passed++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (bus.ram_ready !== (k == 3)) $display("FAIL wr_read_cycle%0d: ram_ready=%b want %b", k, bus.ram_ready, k == 3);
      else passed++;
    end
    checks++; if (bus.ram_data !== 16'hBEEF) $display("FAIL wr_read_data: got %h want beef", bus.ram_data); else passed++;
  endtask

  task automatic test_coherence();
    bit early_drop = 0;
    do_write(16'h0040, 16'h0000);
    bus.rom_address = 16'h0040;
    #1;
    wait_rom_ready("coh_first_fetch");
    checks++; if (bus.rom_data !== 16'h0000) $display("FAIL coh_old_data: got %h want 0000", bus.rom_data); else passed++;
    bus.ram_input = 16'hCAFE;
    #1;
    for (int i = 0; i < 20 && !bus.ram_ready; i++) begin
      tick();
      if (!bus.ram_ready && !bus.rom_ready) early_drop = 1;
    end
    checks++; if (early_drop !== 1'b0) $display("FAIL coh_early_drop: rom_ready fell before commit (%b), want 0", early_drop); else passed++;
    checks++; if (bus.ram_ready !== 1'b1) $display("FAIL coh_write_done: ram_ready=%b want 1", bus.ram_ready); else passed++;
    checks++; if (bus.rom_ready !== 1'b0) $display("FAIL coh_invalidate: rom_ready=%b want 0", bus.rom_ready); else passed++;
    wait_rom_ready("coh_refetch");
    checks++; if (bus.rom_data !== 16'hCAFE) $display("FAIL coh_new_data: got %h want cafe", bus.rom_data); else passed++;
  endtask

  task automatic test_addr_change();
    bus.rom_address = 16'h0005;
    tick();
    bus.rom_address = 16'h0006;
    tick();
    tick();
    checks++; if (bus.rom_ready !== 1'b0) $display("FAIL chg_stale_ready: rom_ready=%b want 0", bus.rom_ready); else passed++;
    checks++; if (bus.rom_data !== 16'h0505) $display("FAIL chg_stale_data: got %h want 0505", bus.rom_data); else passed++;
    tick();
    tick();
    checks++; if (bus.rom_ready !== 1'b0) $display("FAIL chg_mid_second: rom_ready=%b want 0", bus.rom_ready); else passed++;
    tick();
    checks++; if (bus.rom_ready !== 1'b1) $display("FAIL chg_second_ready: rom_ready=%b want 1", bus.rom_ready); else passed++;
    checks++; if (bus.rom_data !== 16'h0606) $display("FAIL chg_second_data: got %h want 0606", bus.rom_data); else passed++;
  endtask

  task automatic test_reset_mid_write();
    bus.ram_write  = 1'b1;
    bus.ram_adress = 16'h0010;
    bus.ram_input  = 16'hDEAD;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.rom_ready, bus.ram_ready} !== 2'b00) $display("FAIL rmw_reset_ready: got %b want 00", {bus.rom_ready, bus.ram_ready});
    else passed++;
    tick();
    bus.ram_write = 1'b0;
    rst = 1'b0;
    #1;
    wait_ram_ready("rmw_read");
    checks++; if (bus.ram_data !== 16'h0007) $display("FAIL rmw_old_value: got %h want 0007", bus.ram_data); else passed++;
  endtask

  // Both ports kept pending by moving each address as soon as it is served.
  task automatic test_arbitration();
    logic [1:0] exp;
    rst = 1'b1;
    bus.rom_address = 16'h0100;
    bus.ram_write   = 1'b0;
    bus.ram_adress  = 16'h0102;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = {(k == 6) || (k == 12), (k == 3) || (k == 9)};
      checks++;
      if ({bus.rom_ready, bus.ram_ready} !== exp)
        $display("FAIL arb_cycle%0d: {rom,ram}_ready=%b want %b", k, {bus.rom_ready, bus.ram_ready}, exp);
      else passed++;
      if (bus.ram_ready) begin
        checks++;
        if (bus.ram_data !== ((k == 3) ? 16'h3333 : 16'h4444)) $display("FAIL arb_ram_data%0d: got %h", k, bus.ram_data);
        else passed++;
        bus.ram_adress = bus.ram_adress ^ 16'h0001;
      end
      if (bus.rom_ready) begin
        checks++;
        if (bus.rom_data !== ((k == 6) ? 16'h1111 : 16'h2222)) $display("FAIL arb_rom_data%0d: got %h", k, bus.rom_data);
        else passed++;
        bus.rom_address = bus.rom_address ^ 16'h0001;
      end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_first_fetch();
    test_write_read();
    test_coherence();
    test_addr_change();
    test_reset_mid_write();
    test_arbitration();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
    $fatal(1, "watchdog");
  end

endmodule
